mac_dot_acc_pipe: RTL and testbench

- Parametrised successor to the fixed 8-bit x4 DSP dot-product MAC used as an OpenCL HDL library function.
- Computes an N-lane signed/unsigned dot product through a registered multiply and adder-tree pipeline.
- Optionally accumulates dot products across a group of beats delimited by first/last flags, with optional saturation.
- Adds real valid/ready flow control, so it sits directly in the PE datapath between the operand buffers and the output drain.

---
 rtl/mac_dot_acc_pipe.sv | 171 +++++++++++++++++
 tb/tb_mac_dot_acc_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_acc_pipe.sv
// N-lane dot-product MAC with a registered multiply/adder-tree pipeline,
// optional group accumulation with saturation, and valid/ready flow control.
module mac_dot_acc_pipe #(
    parameter int unsigned NUM_LANES    = 4,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned A_SIGNED     = 1,
    parameter int unsigned B_SIGNED     = 1,
    parameter int unsigned RESULT_WIDTH = 32,
    parameter int unsigned ACCUM_EN     = 1,
    parameter int unsigned SATURATE     = 0
) (
    input  logic                              clock,
    input  logic                              resetn,
    input  logic                              ivalid,
    output logic                              oready,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]   dataa,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]   datab,
    input  logic                              ifirst,
    input  logic                              ilast,
    output logic                              ovalid,
    input  logic                              iready,
    output logic [RESULT_WIDTH-1:0]           result
);

    localparam int unsigned BUS_W  = NUM_LANES * DATA_WIDTH;
    localparam int unsigned PROD_W = 2 * DATA_WIDTH + 1;
    localparam int unsigned RW     = RESULT_WIDTH;

    // S1: operands and flags
    logic                     s1_valid_q;
    logic [BUS_W-1:0]         s1_a_q;
    logic [BUS_W-1:0]         s1_b_q;
    logic                     s1_first_q;
    logic                     s1_last_q;

    // S2: lane products
    logic                     s2_valid_q;
    logic signed [PROD_W-1:0] s2_prod_q [NUM_LANES];
    logic signed [PROD_W-1:0] s2_prod_d [NUM_LANES];
    logic                     s2_first_q;
    logic                     s2_last_q;

    // S3: reduced sum
    logic                     s3_valid_q;
    logic signed [RW-1:0]     s3_sum_q;
    logic signed [RW-1:0]     s3_sum_d;
    logic                     s3_first_q;
    logic                     s3_last_q;

    // S4: accumulator and output register
    logic signed [RW-1:0]     acc_q;
    logic signed [RW-1:0]     acc_d;
    logic [RW-1:0]            result_q;
    logic [RW-1:0]            result_d;
    logic                     ovalid_q;
    logic                     ovalid_d;

    logic signed [RW-1:0]     acc_base;
    logic signed [RW:0]       acc_wide;
    logic signed [RW-1:0]     acc_next;

    logic                     enable;

    // Whole pipeline advances in lockstep unless a held result is blocked
    assign enable = !ovalid_q || iready;
    assign oready = enable && !resetn;
    assign ovalid = ovalid_q;
    assign result = result_q;

    // Extend each lane per its signedness and multiply at full product width
    always_comb begin : lane_multiply
        logic signed [PROD_W-1:0] a_ext;
        logic signed [PROD_W-1:0] b_ext;
        logic [DATA_WIDTH-1:0]    lane_a;
        logic [DATA_WIDTH-1:0]    lane_b;
        a_ext  = '0;
        b_ext  = '0;
        lane_a = '0;
        lane_b = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            lane_a = s1_a_q[i*DATA_WIDTH +: DATA_WIDTH];
            lane_b = s1_b_q[i*DATA_WIDTH +: DATA_WIDTH];
            a_ext  = (A_SIGNED != 0) ? PROD_W'($signed(lane_a)) : PROD_W'(lane_a);
            b_ext  = (B_SIGNED != 0) ? PROD_W'($signed(lane_b)) : PROD_W'(lane_b);
            s2_prod_d[i] = a_ext * b_ext;
        end
    end

    // Sign-extended reduction of lane products; synthesis balances it into a tree
    always_comb begin : adder_tree
        s3_sum_d = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            s3_sum_d = s3_sum_d + RW'(s2_prod_q[i]);
        end
    end

    // Accumulate/emit decision for the beat arriving at S4
    always_comb begin : accumulate
        acc_base = s3_first_q ? '0 : acc_q;
        acc_wide = {acc_base[RW-1], acc_base} + {s3_sum_q[RW-1], s3_sum_q};
        acc_next = acc_wide[RW-1:0];
        if ((SATURATE != 0) && (acc_wide[RW] != acc_wide[RW-1])) begin
            acc_next = acc_wide[RW] ? {1'b1, {(RW-1){1'b0}}} : {1'b0, {(RW-1){1'b1}}};
        end

        acc_d    = acc_q;
        result_d = result_q;
        ovalid_d = ovalid_q;
        if (enable) begin
            ovalid_d = 1'b0;
            if (s3_valid_q) begin
                if (ACCUM_EN == 0) begin
                    result_d = s3_sum_q;
                    ovalid_d = 1'b1;
                end else if (s3_last_q) begin
                    result_d = acc_next;
                    ovalid_d = 1'b1;
                    acc_d    = '0;
                end else begin
                    acc_d    = acc_next;
                end
            end
        end
    end

    // Pipeline registers with synchronous active-high reset
    always_ff @(posedge clock) begin
        if (resetn) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            for (int i = 0; i < int'(NUM_LANES); i++) begin
                s2_prod_q[i] <= '0;
            end
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_sum_q   <= '0;
            s3_first_q <= 1'b0;
            s3_last_q  <= 1'b0;
            acc_q      <= '0;
            result_q   <= '0;
            ovalid_q   <= 1'b0;
        end else begin
            if (enable) begin
                s1_valid_q <= ivalid;
                s1_a_q     <= dataa;
                s1_b_q     <= datab;
                s1_first_q <= ifirst;
                s1_last_q  <= ilast;
                s2_valid_q <= s1_valid_q;
                for (int i = 0; i < int'(NUM_LANES); i++) begin
                    s2_prod_q[i] <= s2_prod_d[i];
                end
                s2_first_q <= s1_first_q;
                s2_last_q  <= s1_last_q;
                s3_valid_q <= s2_valid_q;
                s3_sum_q   <= s3_sum_d;
                s3_first_q <= s2_first_q;
                s3_last_q  <= s2_last_q;
            end
            acc_q    <= acc_d;
            result_q <= result_d;
            ovalid_q <= ovalid_d;
        end
    end

endmodule

// File: tb/tb_mac_dot_acc_pipe.sv
// Directed bench for mac_dot_acc_pipe: five configurations share one stimulus bus.
module tb_mac_dot_acc_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        ivalid;
    logic        ifirst;
    logic        ilast;
    logic        iready;
    logic [31:0] dataa;
    logic [31:0] datab;

    logic        oready0, ovalid0, oreadyu, ovalidu, oready1, ovalid1;
    logic        oreadys, ovalids, oreadyw, ovalidw;
    logic [31:0] res0, resu, res1;
    logic [17:0] ress, resw;

    int checks = 0;
    int errors = 0;
    int bp_seen = 0;
    bit bp_mon = 0;

    longint q0[$], qu[$], q1[$], qs[$], qw[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        longint      exp_s;
        longint      exp_u;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    // Signed, ACCUM_EN=0
    mac_dot_acc_pipe #(.NUM_LANES(4), .DATA_WIDTH(8), .A_SIGNED(1), .B_SIGNED(1),
                       .RESULT_WIDTH(32), .ACCUM_EN(0), .SATURATE(0)) u_acc0 (
        .clock(clk), .resetn(rst), .ivalid(ivalid), .oready(oready0), .dataa(dataa),
        .datab(datab), .ifirst(ifirst), .ilast(ilast), .ovalid(ovalid0),
        .iready(iready), .result(res0));

    // Unsigned A, ACCUM_EN=0
    mac_dot_acc_pipe #(.NUM_LANES(4), .DATA_WIDTH(8), .A_SIGNED(0), .B_SIGNED(1),
                       .RESULT_WIDTH(32), .ACCUM_EN(0), .SATURATE(0)) u_uns (
        .clock(clk), .resetn(rst), .ivalid(ivalid), .oready(oreadyu), .dataa(dataa),
        .datab(datab), .ifirst(ifirst), .ilast(ilast), .ovalid(ovalidu),
        .iready(iready), .result(resu));

    // Accumulating, wrapping, 32-bit
    mac_dot_acc_pipe #(.NUM_LANES(4), .DATA_WIDTH(8), .A_SIGNED(1), .B_SIGNED(1),
                       .RESULT_WIDTH(32), .ACCUM_EN(1), .SATURATE(0)) u_acc1 (
        .clock(clk), .resetn(rst), .ivalid(ivalid), .oready(oready1), .dataa(dataa),
        .datab(datab), .ifirst(ifirst), .ilast(ilast), .ovalid(ovalid1),
        .iready(iready), .result(res1));

    // Accumulating, saturating, minimum width
    mac_dot_acc_pipe #(.NUM_LANES(4), .DATA_WIDTH(8), .A_SIGNED(1), .B_SIGNED(1),
                       .RESULT_WIDTH(18), .ACCUM_EN(1), .SATURATE(1)) u_sat (
        .clock(clk), .resetn(rst), .ivalid(ivalid), .oready(oreadys), .dataa(dataa),
        .datab(datab), .ifirst(ifirst), .ilast(ilast), .ovalid(ovalids),
        .iready(iready), .result(ress));

    // Accumulating, wrapping, minimum width
    mac_dot_acc_pipe #(.NUM_LANES(4), .DATA_WIDTH(8), .A_SIGNED(1), .B_SIGNED(1),
                       .RESULT_WIDTH(18), .ACCUM_EN(1), .SATURATE(0)) u_wrap (
        .clock(clk), .resetn(rst), .ivalid(ivalid), .oready(oreadyw), .dataa(dataa),
        .datab(datab), .ifirst(ifirst), .ilast(ilast), .ovalid(ovalidw),
        .iready(iready), .result(resw));

    function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
        return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until u_acc0 accepts it (bounded)
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic f, input logic l);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        dataa = a; datab = b; ifirst = f; ilast = l; ivalid = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = oready0;
            tick();
            n++;
            if (!done && n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout got 0 expected 1");
                done = 1;
            end
        end
        ivalid = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        q0.delete(); qu.delete(); q1.delete(); qs.delete(); qw.delete();
    endtask

    task automatic chk_q(input string nm, input longint q[$], input longint exp[$]);
        chk({nm, "_count"}, longint'(q.size()), longint'(exp.size()));
        for (int i = 0; i < exp.size() && i < q.size(); i++) begin
            chk($sformatf("%s_%0d", nm, i), q[i], exp[i]);
        end
    endtask

    // Collect every output transfer; the transfer happens at the following rising edge
    always @(negedge clk) begin
        if (!rst) begin
            if (ovalid0 && iready) q0.push_back(longint'($signed(res0)));
            if (ovalidu && iready) qu.push_back(longint'($signed(resu)));
            if (ovalid1 && iready) q1.push_back(longint'($signed(res1)));
            if (ovalids && iready) qs.push_back(longint'($signed(ress)));
            if (ovalidw && iready) qw.push_back(longint'($signed(resw)));
            if (bp_mon && ovalid0 && !iready) begin
                bp_seen++;
                chk("bp_oready_low", longint'(oready0), 0);
            end
        end
    end

    initial begin
        longint exp_q[$];
        logic [31:0] v70a, v70b, vm128, v127;

        vecs[0] = '{pk(1, 2, 3, 4),      pk(5, 6, 7, 8),       70,     70};
        vecs[1] = '{pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 65536, -65536};
        vecs[2] = '{pk(-1, -1, -1, -1),  pk(-1, -1, -1, -1),   4,      -1020};
        vecs[3] = '{pk(-1, 2, -3, 4),    pk(5, -6, 7, -8),     -70,    3002};
        vecs[4] = '{pk(127, 127, 127, 127), pk(-128, -128, -128, -128), -65024, -65024};
        vecs[5] = '{pk(-128, 0, 0, 127), pk(127, 0, 0, -1),    -16383, 16129};

        v70a  = pk(1, 2, 3, 4);
        v70b  = pk(5, 6, 7, 8);
        vm128 = pk(-128, -128, -128, -128);
        v127  = pk(127, 127, 127, 127);

        rst = 1'b1; ivalid = 1'b0; ifirst = 1'b0; ilast = 1'b0; iready = 1'b1;
        dataa = '0; datab = '0;
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        chk("rst_ovalid", longint'(ovalid0), 0);
        chk("rst_result", longint'(res0), 0);
        chk("rst_oready", longint'(oready0), 0);
        chk("rst_acc_ovalid", longint'(ovalid1), 0);
        chk("rst_acc_result", longint'(res1), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_oready", longint'(oready0), 1);
        tick();

        // Per-beat dot products with exact 4-cycle latency
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].a, vecs[i].b, 1'b0, 1'b0);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (k < 3) begin
                    chk($sformatf("v%0d_early_ovalid_c%0d", i, k), longint'(ovalid0), 0);
                end else if (k == 3) begin
                    chk($sformatf("v%0d_ovalid", i), longint'(ovalid0), 1);
                    chk($sformatf("v%0d_signed", i), longint'($signed(res0)), vecs[i].exp_s);
                    chk($sformatf("v%0d_uns_ovalid", i), longint'(ovalidu), 1);
                    chk($sformatf("v%0d_unsigned_a", i), longint'($signed(resu)), vecs[i].exp_u);
                end else begin
                    chk($sformatf("v%0d_ovalid_pulse", i), longint'(ovalid0), 0);
                end
            end
            tick();
        end

        // Accumulation groups: first/-/last, single-beat, mid-group restart, orphan last
        reset_dut();
        send(v70a, v70b, 1'b1, 1'b0);
        send(v70a, v70b, 1'b0, 1'b0);
        send(v70a, v70b, 1'b0, 1'b1);
        send(v70a, v70b, 1'b1, 1'b1);
        send(v70a, v70b, 1'b1, 1'b0);
        send(v70a, v70b, 1'b1, 1'b0);
        send(v70a, v70b, 1'b0, 1'b1);
        send(v70a, v70b, 1'b0, 1'b1);
        repeat (8) tick();
        exp_q = '{210, 70, 140, 70};
        chk_q("acc_groups", q1, exp_q);

        // Saturation versus wrap at minimum result width
        reset_dut();
        send(vm128, vm128, 1'b1, 1'b0);
        send(vm128, vm128, 1'b0, 1'b0);
        send(vm128, vm128, 1'b0, 1'b0);
        send(vm128, vm128, 1'b0, 1'b1);
        send(vm128, v127, 1'b1, 1'b0);
        send(vm128, v127, 1'b0, 1'b0);
        send(vm128, v127, 1'b0, 1'b0);
        send(vm128, v127, 1'b0, 1'b1);
        repeat (8) tick();
        exp_q = '{131071, -131072};
        chk_q("sat", qs, exp_q);
        exp_q = '{0, 2048};
        chk_q("wrap", qw, exp_q);
        exp_q = '{262144, -260096};
        chk_q("acc32", q1, exp_q);

        // Backpressure: iready low for four cycles while a stream is in flight
        reset_dut();
        bp_mon = 1;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    send(pk(k, 0, 0, 0), pk(1, 0, 0, 0), 1'b0, 1'b0);
                end
            end
            begin
                repeat (5) tick();
                iready = 1'b0;
                repeat (4) tick();
                iready = 1'b1;
            end
        join
        repeat (10) tick();
        bp_mon = 0;
        chk("bp_stall_seen", longint'(bp_seen > 0), 1);
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        chk_q("bp_order", q0, exp_q);

        // Reset with a partial sum and two beats in flight
        reset_dut();
        send(v70a, v70b, 1'b1, 1'b0);
        send(v70a, v70b, 1'b0, 1'b0);
        repeat (4) tick();
        send(v70a, v70b, 1'b0, 1'b0);
        send(v70a, v70b, 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_oready0", longint'(oready0), 0);
        chk("midrst_oready1", longint'(oready1), 0);
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_release_oready", longint'(oready1), 1);
        tick();
        repeat (6) tick();
        chk("midrst_flushed", longint'(q1.size()), 0);
        send(v70a, v70b, 1'b0, 1'b1);
        repeat (6) tick();
        send(v70a, v70b, 1'b1, 1'b1);
        repeat (6) tick();
        exp_q = '{70, 70};
        chk_q("post_rst", q1, exp_q);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
